// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the boot-time program loader: loader FSM state
// encoding and the default geometry of the instruction memory it fills.
// No ports (package).
// -----------------------------------------------------------------------------
package prog_loader_pkg;

   localparam int ADDR_W_DEF    = 10;
   localparam int DATA_W_DEF    = 16;
   localparam int MAX_WORDS_DEF = 1 << ADDR_W_DEF;

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_CSUM_HI,
      S_CSUM_LO,
      S_DONE,
      S_ERR
   } state_t;

endpackage : prog_loader_pkg

// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
// Bundles the loader's byte-stream handshake, instruction-memory write port
// and status outputs.
//   master : byte source / observer side (drives in_valid, in_data)
//   slave  : the loader (drives in_ready, mem_*, cpu_hold, load_done,
//            load_err, word_count)
// Signals:
//   in_valid, in_data[7:0], in_ready         byte stream handshake
//   mem_we, mem_addr[ADDR_W-1:0], mem_wdata  instruction-memory write port
//   cpu_hold, load_done, load_err            core stall and load status
//   word_count[ADDR_W:0]                     words written so far
// -----------------------------------------------------------------------------
interface prog_loader_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;
   logic [ADDR_W:0]   word_count;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata,
             cpu_hold, load_done, load_err, word_count
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata,
             cpu_hold, load_done, load_err, word_count
   );
endinterface : prog_loader_if

// File: rtl/prog_loader_csum.sv
// -----------------------------------------------------------------------------
// prog_loader_csum
// 16-bit wrapping accumulator of the image's data words, with a compare
// against the checksum word received at the end of the stream.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clr_i          clear the running sum
//   add_en_i       add add_val_i to the running sum this cycle
//   add_val_i      data word to accumulate
//   cmp_val_i      checksum candidate
//   match_o        running sum equals cmp_val_i (combinational)
// -----------------------------------------------------------------------------
module prog_loader_csum (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr_i,
   input  logic        add_en_i,
   input  logic [15:0] add_val_i,
   input  logic [15:0] cmp_val_i,
   output logic        match_o
);

   logic [15:0] sum_q;

   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         sum_q <= '0;
      end else if (add_en_i) begin
         sum_q <= sum_q + add_val_i;   // wraps mod 2^16
      end
   end

   assign match_o = (sum_q == cmp_val_i);

endmodule : prog_loader_csum

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Boot-time program loader. Receives LEN_HI, LEN_LO then LEN big-endian
// 16-bit words over a valid/ready byte stream and writes them to consecutive
// instruction-memory addresses from 0. The core is held (cpu_hold) until the
// whole image is written; a bad length (or bad checksum) leaves it held.
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous, active-high
//   bus     prog_loader_if.slave: in_valid/in_data/in_ready, mem_we/
//           mem_addr/mem_wdata, cpu_hold, load_done, load_err, word_count
// Optional build macro PROG_LOADER_CHECKSUM_EN: when defined, a 16-bit
// checksum word (sum of data words mod 2^16) follows the image and must
// match for the load to complete.
// -----------------------------------------------------------------------------
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_WORDS = MAX_WORDS_DEF
) (
   input  logic          clk,
   input  logic          reset,
   prog_loader_if.slave  bus
);

   state_t            state_q;
   logic [7:0]        hi_q;
   logic [15:0]       len_q;
   logic [ADDR_W:0]   word_count_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              cpu_hold_q;
   logic              load_done_q;
   logic              load_err_q;

   logic              in_ready;
   logic              xfer;
   logic [15:0]       word_d;      // {latched hi byte, current byte}
   logic              last_word;
   logic              len_too_big;

   // Ready is a pure decode of the state so it never depends on in_valid.
   assign in_ready    = (state_q != S_DONE) && (state_q != S_ERR);
   assign xfer        = bus.in_valid && in_ready;
   assign word_d      = {hi_q, bus.in_data};
   assign len_too_big = {1'b0, word_d} > 17'(MAX_WORDS);
   assign last_word   = (32'(word_count_q) + 32'd1) == 32'(len_q);

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam state_t S_TAIL = S_CSUM_HI;
   logic csum_match;

   prog_loader_csum u_csum (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (state_q == S_LEN_HI),
      .add_en_i  (xfer && (state_q == S_DATA_LO)),
      .add_val_i (word_d),
      .cmp_val_i (word_d),
      .match_o   (csum_match)
   );
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_LEN_HI;
         word_count_q <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_hold_q   <= 1'b1;
         load_done_q  <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         mem_we_q    <= 1'b0;
         // Status follows the state one cycle later, so the final write
         // strobe has always retired by the cycle the core is released.
         cpu_hold_q  <= (state_q != S_DONE);
         load_done_q <= (state_q == S_DONE);
         load_err_q  <= (state_q == S_ERR);

         if (xfer) begin
            case (state_q)
               S_LEN_HI: begin
                  hi_q    <= bus.in_data;
                  state_q <= S_LEN_LO;
               end
               S_LEN_LO: begin
                  len_q <= word_d;
                  if (len_too_big)         state_q <= S_ERR;
                  else if (word_d == '0)   state_q <= S_TAIL;
                  else                     state_q <= S_DATA_HI;
               end
               S_DATA_HI: begin
                  hi_q    <= bus.in_data;
                  state_q <= S_DATA_LO;
               end
               S_DATA_LO: begin
                  mem_wdata_q  <= word_d;
                  mem_addr_q   <= word_count_q[ADDR_W-1:0];
                  mem_we_q     <= 1'b1;
                  word_count_q <= word_count_q + 1'b1;
                  state_q      <= last_word ? S_TAIL : S_DATA_HI;
               end
`ifdef PROG_LOADER_CHECKSUM_EN
               S_CSUM_HI: begin
                  hi_q    <= bus.in_data;
                  state_q <= S_CSUM_LO;
               end
               S_CSUM_LO: begin
                  state_q <= csum_match ? S_DONE : S_ERR;
               end
`endif
               default: begin
                  state_q <= state_q;
               end
            endcase
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.cpu_hold   = cpu_hold_q;
   assign bus.load_done  = load_done_q;
   assign bus.load_err   = load_err_q;
   assign bus.word_count = word_count_q;

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Scoreboard bench for prog_loader. Stimulus tasks push the expected memory
// writes (address, word) into a queue as each word is sent; an independent
// monitor pops and compares on every mem_we. Final status of each image is
// derived from the stream rules (length limit, checksum when
// PROG_LOADER_CHECKSUM_EN is defined).
// -----------------------------------------------------------------------------
module tb_prog_loader;
   import prog_loader_pkg::*;

   localparam int AW   = ADDR_W_DEF;
   localparam int MAXW = MAX_WORDS_DEF;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   prog_loader_if #(.ADDR_W(AW), .DATA_W(16)) bus ();

   prog_loader #(.ADDR_W(AW), .DATA_W(16), .MAX_WORDS(MAXW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int addr;
      int data;
   } wr_t;

   wr_t         sb[$];
   logic [15:0] img[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin : mon
      wr_t e;
      if (bus.mem_we === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                     bus.mem_addr, bus.mem_wdata);
         end else begin
            e = sb.pop_front();
            chk("write_addr", 32'(bus.mem_addr), e.addr);
            chk("write_data", 32'(bus.mem_wdata), e.data);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gapmax);
      int t;
      repeat ($urandom_range(0, gapmax)) begin
         bus.in_valid = 1'b0;
         bus.in_data  = 8'($urandom);
         @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      t = 0;
      while (bus.in_ready !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (t >= 40) begin
         n_checks++;
         n_fail++;
         $display("FAIL byte_timeout: in_ready %b, expected 1", bus.in_ready);
      end else begin
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      sb.delete();
   endtask

   task automatic set_img(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(16'($urandom));
   endtask

   // Sends a complete image (len taken literally, words from img) and checks
   // the final status against the stream rules.
   task automatic load_image(input logic [15:0] len, input int gap, input bit bad_csum);
      logic [15:0] sum;
      logic [15:0] w;
      bit          exp_err;
      int          nw;
      int          t;
      wr_t         e;
      sum     = 16'h0;
      exp_err = (int'(len) > MAXW);
      nw      = exp_err ? 0 : int'(len);
      send_byte(len[15:8], gap);
      send_byte(len[7:0], gap);
      for (int i = 0; i < nw; i++) begin
         w = img[i];
         send_byte(w[15:8], gap);
         e.addr = i;
         e.data = int'(w);
         sb.push_back(e);
         send_byte(w[7:0], gap);
         sum = sum + w;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if (!exp_err) begin
         w = bad_csum ? sum + 16'd1 : sum;
         send_byte(w[15:8], gap);
         send_byte(w[7:0], gap);
         exp_err = bad_csum;
      end
`else
      if (bad_csum) $display("note: checksum disabled in this build, bad_csum ignored");
`endif
      t = 0;
      while (!(bus.load_done === 1'b1 || bus.load_err === 1'b1) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("status_in_time", 32'(t < 100), 32'd1);
      @(negedge clk);
      chk("load_done", 32'(bus.load_done), 32'(!exp_err));
      chk("load_err", 32'(bus.load_err), 32'(exp_err));
      chk("cpu_hold", 32'(bus.cpu_hold), 32'(exp_err));
      chk("in_ready_end", 32'(bus.in_ready), 32'd0);
      chk("word_count", 32'(bus.word_count), 32'(nw));
      chk("pending_writes", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic [AW-1:0] s_addr;
      logic [15:0]   s_data;
      logic [AW:0]   s_wc;
      logic [15:0]   w;
      wr_t           e;
      int            n;

      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      reset        = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset values
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
      chk("rst_load_done", 32'(bus.load_done), 32'd0);
      chk("rst_load_err", 32'(bus.load_err), 32'd0);
      chk("rst_word_count", 32'(bus.word_count), 32'd0);

      // Three-word image, back-to-back bytes
      img = '{16'h1234, 16'hABCD, 16'h0001};
      load_image(16'd3, 0, 1'b0);

      // Bytes offered in S_DONE are ignored
      s_addr = bus.mem_addr;
      s_data = bus.mem_wdata;
      s_wc   = bus.word_count;
      repeat (6) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'($urandom);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("done_in_ready", 32'(bus.in_ready), 32'd0);
      chk("done_sticky", 32'(bus.load_done), 32'd1);
      chk("done_hold", 32'(bus.cpu_hold), 32'd0);
      chk("done_word_count", 32'(bus.word_count), 32'(s_wc));
      chk("done_mem_addr", 32'(bus.mem_addr), 32'(s_addr));
      chk("done_mem_wdata", 32'(bus.mem_wdata), 32'(s_data));

      // Empty image
      do_reset();
      load_image(16'd0, 0, 1'b0);

      // Length one past the limit
      do_reset();
      load_image(16'h0401, 0, 1'b0);

      // Largest legal image
      do_reset();
      set_img(MAXW);
      load_image(16'h0400, 0, 1'b0);
      chk("last_addr", 32'(bus.mem_addr), 32'h3FF);

      // Reset in the middle of an 8-word image, random gaps
      do_reset();
      set_img(8);
      send_byte(8'h00, 3);
      send_byte(8'h08, 3);
      for (int i = 0; i < 5; i++) begin
         w = img[i];
         send_byte(w[15:8], 3);
         e.addr = i;
         e.data = int'(w);
         sb.push_back(e);
         send_byte(w[7:0], 3);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_word_count", 32'(bus.word_count), 32'd0);
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_cpu_hold", 32'(bus.cpu_hold), 32'd1);
      chk("abort_load_done", 32'(bus.load_done), 32'd0);
      chk("abort_pending", 32'(sb.size()), 32'd0);
      set_img(2);
      load_image(16'd2, 3, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
      // Checksum good / bad
      do_reset();
      img = '{16'h8000, 16'h8001};
      load_image(16'd2, 1, 1'b0);
      do_reset();
      img = '{16'h8000, 16'h8001};
      load_image(16'd2, 1, 1'b1);
`endif

      // Random images
      for (int k = 0; k < 4; k++) begin
         do_reset();
         n = int'($urandom_range(1, 20));
         set_img(n);
         load_image(16'(n), 3, 1'($urandom_range(0, 1)));
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_prog_loader

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Boot-time program loader sitting directly upstream of the processor core's memory write port. It receives a byte stream over a valid/ready handshake and assembles big-endian 16-bit words. Each word is written to consecutive instruction-memory addresses starting at 0. The core is held in stall (cpu_hold) until the image is complete, then released; on a framing error the core stays held.

Parameters:
ADDR_W, 10, memory address width (matches program counter width)
DATA_W, 16, memory word width
MAX_WORDS, 1024, largest legal image length in words (2**ADDR_W)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  one-cycle write strobe to instruction memory
mem_addr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
cpu_hold  output  1  1 = core stalled (PC and accumulator frozen)
load_done  output  1  image loaded successfully; sticky until reset
load_err  output  1  framing/length/checksum error; sticky until reset
word_count  output  ADDR_W+1  number of words written so far

Behaviour:
- Interface is fixed: one clock (clk); reset is synchronous and active-high (reset).
- Byte transfer occurs on a cycle where in_valid && in_ready are both high. in_data is sampled only on a transfer. in_ready depends only on state, never on in_valid.
- Stream format: LEN_HI, LEN_LO, then LEN words, each sent as hi byte then lo byte. LEN is unsigned 16-bit.
- States:
  - S_LEN_HI: store LEN_HI, then go to S_LEN_LO.
  - S_LEN_LO: on transfer, form len = {hi, lo}.
    - If len > MAX_WORDS, go to S_ERR.
    - If len == 0, go to S_DONE (S_CSUM_HI when checksum enabled).
    - Otherwise go to S_DATA_HI.
  - S_DATA_HI: latch hi byte, then go to S_DATA_LO.
  - S_DATA_LO: on transfer, register mem_wdata = {hi, in_data} and mem_addr = word_count[ADDR_W-1:0], and assert mem_we on the next cycle for exactly one cycle. word_count increments in that same cycle. If word_count+1 == len, go to S_DONE (or S_CSUM_HI); otherwise return to S_DATA_HI.
  - S_DONE: in_ready=0, cpu_hold=0, load_done=1. Terminal until reset.
  - S_ERR: in_ready=0, cpu_hold=1, load_err=1. Terminal until reset.
- in_ready = 1 in every state except S_DONE and S_ERR. Back-to-back bytes with in_valid held high give one word written every 2 cycles.
- Write latency is 1 cycle from the lo-byte transfer to mem_we. mem_addr and mem_wdata stay stable while mem_we is high, and hold their last values otherwise.
- cpu_hold is deasserted in the same cycle load_done rises. The final mem_we has always completed by then, or in that same cycle; the core must not fetch before the cycle after.
- Address never wraps: at most MAX_WORDS writes, addresses 0..MAX_WORDS-1. len == MAX_WORDS is legal; len == MAX_WORDS+1 goes to error.
- Reset values: state=S_LEN_HI, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0, word_count=0.
- Reset mid-load returns to S_LEN_HI immediately and word_count is cleared. Memory words already written are not erased; the next image overwrites them from address 0.
- in_valid while in_ready=0 is ignored; no error is raised.

Optional Feature:
- Macro PROG_LOADER_CHECKSUM_EN.
- Defined: after the last data word (or straight after LEN when len == 0), two extra states S_CSUM_HI and S_CSUM_LO accept a 16-bit checksum. The expected value is the sum of all data words mod 2^16, with 0 for len == 0.
  - On match, go to S_DONE.
  - On mismatch, go to S_ERR. cpu_hold stays 1; written words remain in memory.
- Undefined: the checksum states and the accumulator are absent, and the stream ends after the last data word.

Decomposition:
- Package prog_loader_pkg holds:
  - state enum (S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM_HI, S_CSUM_LO, S_DONE, S_ERR)
  - ADDR_W, DATA_W and MAX_WORDS defaults
- One sub-module, prog_loader_csum: 16-bit wrapping accumulator with clear, add-enable and compare output. It is instantiated only under PROG_LOADER_CHECKSUM_EN.

Test Plan:
- Stream 00 03 12 34 AB CD 00 01, in_valid held high -> mem_we pulses at addr 0/1/2 with data 1234/ABCD/0001; word_count=3; load_done=1; cpu_hold falls; in_ready=0 afterwards.
- Stream 00 00 -> no mem_we; load_done=1 two cycles after the LEN_LO transfer. With CHECKSUM_EN, also send 00 00 -> done.
- Stream 04 01 (len 1025) -> load_err=1, cpu_hold stays 1, no mem_we, in_ready=0. Len 0400 with 1024 words -> last write at addr 3FF, done.
- Random in_valid gaps plus a reset asserted after 5 of 8 words -> state and word_count back to 0. A fresh 2-word image then writes addr 0 and 1 and completes.
- CHECKSUM_EN: words 8000 8001 with checksum 0001 -> done. Same words with checksum 0002 -> load_err=1, cpu_hold=1.
- in_valid pulsed in S_DONE with arbitrary bytes -> no transfer, no mem_we, outputs unchanged.
